nod_link_arbiter: RTL and testbench
===================================

Name: nod_link_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one NoD output link between N_IN buffered requesters.
- Each requester is the valid/ready read side of a NoD FIFO wrapper.
- A grant is held from the head flit through the tail flit, so packets are never interleaved on the link.
- Sits between the per-port NoD FIFOs and the output link or bypass controller.

Parameters:
- N_IN, 4, number of requesters (2..8).
- IDX_W, 2, grant index width; must equal ceil(log2(N_IN)).
- MAX_PKT_LEN, 16, maximum flits per packet, counting head and tail.
- CNT_W, 5, flit counter width; must satisfy 2^CNT_W > MAX_PKT_LEN.
- Data width is `DATA_WIDTH from param.vh.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  N_IN  per-requester flit valid.
- in_data  in  N_IN*`DATA_WIDTH  flattened flits; requester i occupies bits [i*`DATA_WIDTH +: `DATA_WIDTH].
- in_ready  out  N_IN  per-requester pop; a transfer happens when in_valid[i] & in_ready[i].
- out_valid  out  1  link flit valid.
- out_data  out  `DATA_WIDTH  link flit.
- out_ready  in  1  link accepts the flit.
- busy  out  1  high while a packet is locked.
- gnt_idx  out  IDX_W  index of the current or last grant.
- err_hdr  out  1  sticky: a non-head flit was presented while no grant was active.
- err_len  out  1  sticky: a packet exceeded MAX_PKT_LEN flits.

Behaviour:
- Flit type is data[`DATA_WIDTH-1 -: 2]:
  - 00 head, 01 body, 10 tail, 11 single (head and tail).
  - "Head-capable" means 00 or 11; "tail-capable" means 10 or 11.
- Reset, asynchronous and valid at any time including mid-packet:
  - state=IDLE, rr_ptr=0, gnt_idx=0, flit_cnt=0, err_hdr=0, err_len=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - A packet cut by reset is abandoned; upstream FIFO contents are untouched.
- State IDLE:
  - out_valid=0 and in_ready=0.
  - Candidates are requesters with in_valid=1 and a head-capable flit.
  - Pick the first candidate searching rr_ptr, rr_ptr+1, ... modulo N_IN.
  - If a candidate exists, next cycle: gnt_idx <= winner, state=LOCK, flit_cnt=0.
  - Any valid requester showing a non-head flit sets err_hdr, is never granted, and is not popped.
- State LOCK (g = gnt_idx):
  - out_valid = in_valid[g]; out_data = in_data slice g; in_ready[g] = out_ready; in_ready of all others = 0.
  - out_data is combinational from the granted slice; out_data = 0 whenever out_valid=0.
  - On each transfer (in_valid[g] & out_ready), flit_cnt increments, saturating at 2^CNT_W-1.
- Leaving LOCK:
  - A transfer of a tail-capable flit returns to IDLE next cycle with rr_ptr <= (g+1) mod N_IN.
  - A transfer that makes flit_cnt reach MAX_PKT_LEN without tail-capable type sets err_len and force-releases to IDLE, same rr_ptr update.
- Latency and throughput:
  - One bubble cycle per packet (IDLE arbitration cycle); then one flit per cycle while in_valid[g] & out_ready.
  - Fairness: a continuously requesting input waits at most N_IN-1 packets.
- Boundary conditions:
  - in_valid[g] dropping mid-packet keeps the lock, with out_valid=0 for as long as it stays low.
  - out_ready low holds the flit; in_ready[g] is low, so nothing is popped.
  - A single-type flit (11) occupies LOCK for exactly one transfer.
  - A head-capable flit (00 or 11) arriving at the granted input while in LOCK is passed through as an ordinary flit; only a tail-capable flit releases the lock.
  - err_hdr and err_len are sticky; only rstn clears them.
- busy = (state==LOCK).
- No combinational path from out_ready to out_valid.

Test Plan:
1. Reset release, only in_valid[2]=1 with a type 11 flit 0x..AB, out_ready=1:
   - one IDLE cycle, then out_valid=1, out_data=0x..AB, in_ready[2]=1 for one cycle;
   - then IDLE with rr_ptr=3 and gnt_idx=2.
2. All 4 inputs hold 3-flit packets (head, body, tail), out_ready=1:
   - grant order 0,1,2,3,0;
   - each packet is 3 contiguous flits with 1 idle cycle between packets.
3. Input 1 locked, out_ready toggled 1,0,0,1:
   - flits are held stable while out_ready=0;
   - in_ready[1] follows out_ready;
   - no flits are lost or duplicated.
4. Locked input 0 drops in_valid for 3 cycles mid-packet while input 1 requests:
   - out_valid=0 for those cycles;
   - input 1 is not granted until input 0's tail transfers.
5. Body flit (type 01) at input 3 while IDLE, no other requester:
   - err_hdr=1, in_ready[3]=0, no grant.
6. Packet of 17 flits with no tail (MAX_PKT_LEN=16):
   - err_len=1 on the 16th transfer, then forced IDLE;
   - assert rstn=0 mid-packet in a rerun: all outputs 0 immediately.

Source files
------------

// File: rtl/nod_link_arbiter.sv
// -----------------------------------------------------------------------------
// nod_link_arbiter
//
// Round-robin, packet-locked arbiter sharing one NoD output link between N_IN
// buffered requesters (valid/ready read sides of per-port NoD FIFOs). Once a
// requester is granted on a head-capable flit, the grant is held until a
// tail-capable flit transfers (or the packet overruns MAX_PKT_LEN), so packets
// are never interleaved on the link.
//
// Flit type = data[DATA_WIDTH-1 -: 2]: 00 head, 01 body, 10 tail, 11 single.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   in_valid   per-requester flit valid
//   in_data    flattened flits, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   per-requester pop (transfer when in_valid[i] & in_ready[i])
//   out_valid  link flit valid
//   out_data   link flit (zero whenever out_valid is low)
//   out_ready  link accepts the flit
//   busy       a packet is locked
//   gnt_idx    index of the current or last grant
//   err_hdr    sticky: non-head flit presented with no grant active
//   err_len    sticky: packet exceeded MAX_PKT_LEN flits
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module nod_link_arbiter #(
    parameter int N_IN        = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_PKT_LEN = 16,
    parameter int CNT_W       = 5
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_IN-1:0]               in_valid,
    input  logic [N_IN*`DATA_WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]               in_ready,
    output logic                          out_valid,
    output logic [`DATA_WIDTH-1:0]        out_data,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [IDX_W-1:0]              gnt_idx,
    output logic                          err_hdr,
    output logic                          err_len
);

    localparam int DW = `DATA_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]  gnt_idx_reg, gnt_idx_next;
    logic [CNT_W-1:0]  flit_cnt_reg, flit_cnt_next;
    logic              err_hdr_reg, err_hdr_next;
    logic              err_len_reg, err_len_next;

    // Per-requester flit classification.
    logic [N_IN-1:0] head_cap;
    logic [N_IN-1:0] tail_cap;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_type
            logic [1:0] flit_type;
            assign flit_type    = in_data[gi*DW + DW - 2 +: 2];
            assign head_cap[gi] = (flit_type == 2'b00) || (flit_type == 2'b11);
            assign tail_cap[gi] = flit_type[1];
        end
    endgenerate

    logic [N_IN-1:0] cand;
    logic            bad_hdr;

    assign cand    = in_valid & head_cap;
    assign bad_hdr = |(in_valid & ~head_cap);

    // Rotating first-candidate search starting at rr_ptr.
    logic             found;
    logic [IDX_W-1:0] winner;

    always_comb begin
        int p;
        found  = 1'b0;
        winner = '0;
        p      = 0;
        for (int k = 0; k < N_IN; k++) begin
            p = (int'(rr_ptr_reg) + k) % N_IN;
            if (!found && cand[p]) begin
                found  = 1'b1;
                winner = IDX_W'(p);
            end
        end
    end

    // Granted requester view.
    logic          lock;
    logic          g_valid;
    logic          g_tail;
    logic [DW-1:0] g_data;

    assign lock    = (state_reg == S_LOCK);
    assign g_valid = in_valid[gnt_idx_reg];
    assign g_tail  = tail_cap[gnt_idx_reg];
    assign g_data  = in_data[int'(gnt_idx_reg)*DW +: DW];

    // Link outputs depend only on state and requester signals; out_ready only
    // feeds in_ready, never out_valid.
    always_comb begin
        out_valid = lock && g_valid;
        out_data  = out_valid ? g_data : '0;
        in_ready  = '0;
        if (lock && out_ready) begin
            in_ready[gnt_idx_reg] = 1'b1;
        end
    end

    // Next-state logic.
    logic [CNT_W-1:0] cnt_inc;
    logic [IDX_W-1:0] rr_after;

    assign cnt_inc  = (flit_cnt_reg == {CNT_W{1'b1}}) ? flit_cnt_reg : flit_cnt_reg + 1'b1;
    assign rr_after = IDX_W'((int'(gnt_idx_reg) + 1) % N_IN);

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        gnt_idx_next  = gnt_idx_reg;
        flit_cnt_next = flit_cnt_reg;
        err_hdr_next  = err_hdr_reg;
        err_len_next  = err_len_reg;
        case (state_reg)
            S_IDLE: begin
                if (bad_hdr) begin
                    err_hdr_next = 1'b1;
                end
                if (found) begin
                    gnt_idx_next  = winner;
                    flit_cnt_next = '0;
                    state_next    = S_LOCK;
                end
            end
            S_LOCK: begin
                if (g_valid && out_ready) begin
                    flit_cnt_next = cnt_inc;
                    if (g_tail) begin
                        state_next  = S_IDLE;
                        rr_ptr_next = rr_after;
                    end else if (cnt_inc == CNT_W'(MAX_PKT_LEN)) begin
                        // Runaway packet: flag it and free the link.
                        err_len_next = 1'b1;
                        state_next   = S_IDLE;
                        rr_ptr_next  = rr_after;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            rr_ptr_reg   <= '0;
            gnt_idx_reg  <= '0;
            flit_cnt_reg <= '0;
            err_hdr_reg  <= 1'b0;
            err_len_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            gnt_idx_reg  <= gnt_idx_next;
            flit_cnt_reg <= flit_cnt_next;
            err_hdr_reg  <= err_hdr_next;
            err_len_reg  <= err_len_next;
        end
    end

    assign busy    = lock;
    assign gnt_idx = gnt_idx_reg;
    assign err_hdr = err_hdr_reg;
    assign err_len = err_len_reg;

endmodule

// File: tb/tb_nod_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nod_link_arbiter
//
// Directed bench for nod_link_arbiter (N_IN=4, DATA_WIDTH=32). Each requester
// is modelled as a FIFO queue whose head drives in_data/in_valid and which is
// popped when in_valid & in_ready at a clock edge. Expected values are
// hand-computed per step.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_nod_link_arbiter;

    localparam int N  = 4;
    localparam int DW = `DATA_WIDTH;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic              busy;
    logic [1:0]        gnt_idx;
    logic              err_hdr;
    logic              err_len;

    nod_link_arbiter #(
        .N_IN(4), .IDX_W(2), .MAX_PKT_LEN(16), .CNT_W(5)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .gnt_idx(gnt_idx), .err_hdr(err_hdr), .err_len(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
    logic [N-1:0]  hold;
    logic [DW-1:0] xlog[$];

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [29:0] pl);
        return {t, pl};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        in_valid[0] = (q0.size() != 0) && !hold[0];
        in_valid[1] = (q1.size() != 0) && !hold[1];
        in_valid[2] = (q2.size() != 0) && !hold[2];
        in_valid[3] = (q3.size() != 0) && !hold[3];
        in_data[0*DW +: DW] = (q0.size() != 0) ? q0[0] : '0;
        in_data[1*DW +: DW] = (q1.size() != 0) ? q1[0] : '0;
        in_data[2*DW +: DW] = (q2.size() != 0) ? q2[0] : '0;
        in_data[3*DW +: DW] = (q3.size() != 0) ? q3[0] : '0;
    endtask

    // One clock: sample transfers, wait for edge, pop FIFOs, re-drive inputs.
    task automatic cyc();
        logic [N-1:0] popped;
        #1;
        popped = in_valid & in_ready;
        if (out_valid && out_ready) xlog.push_back(out_data);
        @(posedge clk);
        #1;
        if (popped[0]) void'(q0.pop_front());
        if (popped[1]) void'(q1.pop_front());
        if (popped[2]) void'(q2.pop_front());
        if (popped[3]) void'(q3.pop_front());
        refresh();
        #1;
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        hold = '0;
        xlog.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_q();
        refresh();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] exp_flit;
    int            order[5];

    initial begin
        rstn      = 1'b0;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        hold      = '0;
        #1;
        // ---- reset state ----
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_in_ready", DW'(in_ready), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_gnt", DW'(gnt_idx), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_errs", DW'({err_hdr, err_len}), 0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;

        // ---- 1: single flit at input 2 ----
        out_ready = 1'b1;
        q2.push_back(mk(2'b11, 30'hAB));
        refresh();
        #1;
        chk("t1_idle_busy", DW'(busy), 0);
        chk("t1_idle_ovalid", DW'(out_valid), 0);
        chk("t1_idle_iready", DW'(in_ready), 0);
        cyc();
        chk("t1_lock_busy", DW'(busy), 1);
        chk("t1_lock_gnt", DW'(gnt_idx), 2);
        chk("t1_lock_ovalid", DW'(out_valid), 1);
        chk("t1_lock_odata", out_data, 32'hC00000AB);
        chk("t1_lock_iready", DW'(in_ready), 4'b0100);
        cyc();
        chk("t1_done_busy", DW'(busy), 0);
        chk("t1_done_ovalid", DW'(out_valid), 0);
        chk("t1_done_odata", out_data, 0);
        chk("t1_done_gnt", DW'(gnt_idx), 2);
        // rr_ptr should now be 3: input 3 wins over input 1.
        q1.push_back(mk(2'b11, 30'h11));
        q3.push_back(mk(2'b11, 30'h33));
        refresh();
        cyc();
        chk("t1_rr3_gnt", DW'(gnt_idx), 3);
        chk("t1_rr3_odata", out_data, 32'hC0000033);
        cyc();
        cyc();
        chk("t1_wrap_gnt", DW'(gnt_idx), 1);
        cyc();
        chk("t1_errs", DW'({err_hdr, err_len}), 0);

        // ---- 2: four 3-flit packets, round robin ----
        do_reset();
        out_ready = 1'b1;
        q0.push_back(mk(2'b00, 30'h000)); q0.push_back(mk(2'b01, 30'h001)); q0.push_back(mk(2'b10, 30'h002));
        q1.push_back(mk(2'b00, 30'h010)); q1.push_back(mk(2'b01, 30'h011)); q1.push_back(mk(2'b10, 30'h012));
        q2.push_back(mk(2'b00, 30'h020)); q2.push_back(mk(2'b01, 30'h021)); q2.push_back(mk(2'b10, 30'h022));
        q3.push_back(mk(2'b00, 30'h030)); q3.push_back(mk(2'b01, 30'h031)); q3.push_back(mk(2'b10, 30'h032));
        q0.push_back(mk(2'b00, 30'h100)); q0.push_back(mk(2'b01, 30'h101)); q0.push_back(mk(2'b10, 30'h102));
        refresh();
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        for (int pk = 0; pk < 5; pk++) begin
            cyc();
            chk($sformatf("t2_p%0d_gnt", pk), DW'(gnt_idx), DW'(order[pk]));
            for (int f = 0; f < 3; f++) begin
                exp_flit = {f[1:0] == 2'd0 ? 2'b00 : (f[1:0] == 2'd1 ? 2'b01 : 2'b10),
                            30'((pk == 4 ? 32'h100 : 32'(order[pk]) * 32'h10) + 32'(f))};
                chk($sformatf("t2_p%0d_f%0d_ovalid", pk, f), DW'(out_valid), 1);
                chk($sformatf("t2_p%0d_f%0d_odata", pk, f), out_data, exp_flit);
                chk($sformatf("t2_p%0d_f%0d_iready", pk, f), DW'(in_ready), DW'(4'b0001 << order[pk]));
                cyc();
            end
            chk($sformatf("t2_p%0d_bubble", pk), DW'({busy, out_valid}), 0);
        end
        chk("t2_xfers", DW'(xlog.size()), 15);

        // ---- 3: backpressure on input 1 ----
        do_reset();
        out_ready = 1'b1;
        q1.push_back(mk(2'b00, 30'hA0)); q1.push_back(mk(2'b01, 30'hA1)); q1.push_back(mk(2'b10, 30'hA2));
        refresh();
        cyc();
        chk("t3_gnt", DW'(gnt_idx), 1);
        chk("t3_f0_odata", out_data, 32'h000000A0);
        chk("t3_f0_iready", DW'(in_ready), 4'b0010);
        cyc();
        out_ready = 1'b0;
        #1;
        chk("t3_hold0_odata", out_data, 32'h400000A1);
        chk("t3_hold0_iready", DW'(in_ready), 0);
        cyc();
        chk("t3_hold1_odata", out_data, 32'h400000A1);
        chk("t3_hold1_ovalid", DW'(out_valid), 1);
        chk("t3_hold1_iready", DW'(in_ready), 0);
        cyc();
        out_ready = 1'b1;
        #1;
        chk("t3_resume_odata", out_data, 32'h400000A1);
        chk("t3_resume_iready", DW'(in_ready), 4'b0010);
        cyc();
        chk("t3_f2_odata", out_data, 32'h800000A2);
        cyc();
        chk("t3_end_busy", DW'(busy), 0);
        chk("t3_xfers", DW'(xlog.size()), 3);
        if (xlog.size() == 3) begin
            chk("t3_log0", xlog[0], 32'h000000A0);
            chk("t3_log1", xlog[1], 32'h400000A1);
            chk("t3_log2", xlog[2], 32'h800000A2);
        end

        // ---- 4: granted input stalls, competitor waits ----
        do_reset();
        out_ready = 1'b1;
        q0.push_back(mk(2'b00, 30'hC0)); q0.push_back(mk(2'b01, 30'hC1));
        q0.push_back(mk(2'b01, 30'hC2)); q0.push_back(mk(2'b10, 30'hC3));
        q1.push_back(mk(2'b11, 30'hD1));
        refresh();
        cyc();
        chk("t4_gnt0", DW'(gnt_idx), 0);
        cyc();
        hold[0] = 1'b1;
        refresh();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_stall%0d_ovalid", k), DW'(out_valid), 0);
            chk($sformatf("t4_stall%0d_odata", k), out_data, 0);
            chk($sformatf("t4_stall%0d_lock", k), DW'({busy, gnt_idx}), 3'b100);
            chk($sformatf("t4_stall%0d_iready1", k), DW'(in_ready[1]), 0);
            cyc();
        end
        hold[0] = 1'b0;
        refresh();
        #1;
        chk("t4_resume_odata", out_data, 32'h400000C1);
        cyc();
        cyc();
        chk("t4_tail_odata", out_data, 32'h800000C3);
        cyc();
        chk("t4_release_busy", DW'(busy), 0);
        cyc();
        chk("t4_gnt1", DW'(gnt_idx), 1);
        chk("t4_gnt1_odata", out_data, 32'hC00000D1);
        cyc();
        chk("t4_xfers", DW'(xlog.size()), 5);

        // ---- 5: body flit with no grant ----
        do_reset();
        out_ready = 1'b1;
        q3.push_back(mk(2'b01, 30'h55));
        refresh();
        cyc();
        chk("t5_err_hdr", DW'(err_hdr), 1);
        chk("t5_iready", DW'(in_ready), 0);
        chk("t5_busy", DW'(busy), 0);
        cyc();
        chk("t5_nogrant", DW'({busy, gnt_idx}), 0);
        chk("t5_notpopped", DW'(q3.size()), 1);
        q3.delete();
        refresh();
        cyc();
        chk("t5_sticky", DW'({err_hdr, err_len}), 2'b10);

        // ---- 6: 17-flit packet with no tail ----
        do_reset();
        out_ready = 1'b1;
        q2.push_back(mk(2'b00, 30'h600));
        for (int k = 1; k <= 16; k++) q2.push_back(mk(2'b01, 30'(32'h600 + 32'(k))));
        refresh();
        cyc();
        chk("t6_gnt", DW'(gnt_idx), 2);
        for (int n = 1; n <= 16; n++) begin
            cyc();
            if (n == 15) chk("t6_n15_state", DW'({err_len, busy}), 2'b01);
        end
        chk("t6_err_len", DW'(err_len), 1);
        chk("t6_forced_idle", DW'({busy, out_valid}), 0);
        cyc();
        chk("t6_leftover_hdr", DW'(err_hdr), 1);
        chk("t6_leftover_iready", DW'(in_ready), 0);
        chk("t6_leftover_busy", DW'(busy), 0);
        // Rerun with reset asserted mid-packet.
        q2.delete();
        q2.push_back(mk(2'b00, 30'h700));
        for (int k = 1; k <= 5; k++) q2.push_back(mk(2'b01, 30'(32'h700 + 32'(k))));
        refresh();
        cyc();
        cyc();
        cyc();
        chk("t6_rerun_busy", DW'({busy, gnt_idx}), 3'b110);
        rstn = 1'b0;
        #1;
        chk("t6_arst_ovalid", DW'(out_valid), 0);
        chk("t6_arst_odata", out_data, 0);
        chk("t6_arst_iready", DW'(in_ready), 0);
        chk("t6_arst_busy_gnt", DW'({busy, gnt_idx}), 0);
        chk("t6_arst_errs", DW'({err_hdr, err_len}), 0);
        chk("t6_arst_fifo", DW'(q2.size()), 4);
        #3;
        rstn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
